// File: rtl/spi_master_sched.sv
// -----------------------------------------------------------------------------
// spi_master_sched
//   SPI master with a built-in requester scheduler. NUM_REQ local requesters
//   compete for one SPI link. The winner's word is sent MSB-first on mosi
//   (SPI mode 0). sclk and the active-low chip select latch are generated from
//   clk_in, and miso is captured into rx_data. This block drives the existing
//   SIPO receiver: si <= mosi, clk <= sclk, latch_r <= latch,
//   trans_done <= frame_done.
//
//   Build option: define SPI_SCHED_FIXED_PRIO_EN to select fixed priority
//   (the lowest index always wins, no round-robin pointer). When it is not
//   defined (the default), arbitration is round-robin.
//
// Ports
//   clk_in      in   system clock
//   reset       in   synchronous, active-high reset
//   req         in   [NUM_REQ]         per-requester request level
//   tx_data     in   [NUM_REQ*DATA_W]  requester i word at [i*DATA_W +: DATA_W]
//   gnt         out  [NUM_REQ]         one-hot grant, held for the whole frame
//   done        out  [NUM_REQ]         1-cycle pulse to the owner at frame end
//   rx_data     out  [DATA_W]          last received word
//   busy        out  high from grant until the inter-frame gap ends
//   frame_done  out  1-cycle pulse, OR of done
//   sclk        out  SPI clock, idles low
//   latch       out  chip select, active low, idles high
//   mosi        out  serial data out
//   miso        in   serial data in
// -----------------------------------------------------------------------------
module spi_master_sched #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic                      clk_in,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] tx_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      sclk,
    output logic                      latch,
    output logic                      mosi,
    input  logic                      miso
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int GAP_W = $clog2(CS_GAP + 1);
    localparam int PTR_W = $clog2(NUM_REQ);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
    localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(CS_GAP);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t              state_r,      state_s;
    logic [DIV_W-1:0]    div_cnt_r,    div_cnt_s;
    logic [BIT_W-1:0]    bit_cnt_r,    bit_cnt_s;
    logic [GAP_W-1:0]    gap_cnt_r,    gap_cnt_s;
    logic [DATA_W-1:0]   tx_sh_r,      tx_sh_s;   // MSB is mosi; zeros shift in
    logic [DATA_W-1:0]   rx_sh_r,      rx_sh_s;
    logic [NUM_REQ-1:0]  gnt_r,        gnt_s;
    logic [NUM_REQ-1:0]  done_r,       done_s;
    logic [DATA_W-1:0]   rx_data_r,    rx_data_s;
    logic                busy_r,       busy_s;
    logic                frame_done_r, frame_done_s;
    logic                sclk_r,       sclk_s;
    logic                latch_r,      latch_s;

    logic                win_found_s;
    logic [PTR_W-1:0]    win_idx_s;
    logic [DATA_W-1:0]   win_word_s;

`ifndef SPI_SCHED_FIXED_PRIO_EN
    logic [PTR_W-1:0]    rr_ptr_r,     rr_ptr_s;
`endif

    // Arbiter: pick this cycle's winner among the active requests.
    always_comb begin
        logic [PTR_W-1:0] cand_v;
        cand_v      = '0;
        win_found_s = 1'b0;
        win_idx_s   = '0;
`ifdef SPI_SCHED_FIXED_PRIO_EN
        // Scan high to low so the lowest active index is the last to overwrite.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand_v      = PTR_W'(i);
            win_idx_s   = req[cand_v] ? cand_v : win_idx_s;
            win_found_s = req[cand_v] ? 1'b1   : win_found_s;
        end
`else
        // Scan offsets far to near from the pointer; the nearest offset after
        // the last winner overwrites last, which gives the round-robin order.
        for (int o = NUM_REQ; o >= 1; o--) begin
            cand_v      = PTR_W'((int'(rr_ptr_r) + o) % NUM_REQ);
            win_idx_s   = req[cand_v] ? cand_v : win_idx_s;
            win_found_s = req[cand_v] ? 1'b1   : win_found_s;
        end
`endif
        win_word_s = tx_data[int'(win_idx_s) * DATA_W +: DATA_W];
    end

    // Frame sequencer: next state and next values of all registered outputs.
    always_comb begin
        state_s      = state_r;
        div_cnt_s    = div_cnt_r;
        bit_cnt_s    = bit_cnt_r;
        gap_cnt_s    = gap_cnt_r;
        tx_sh_s      = tx_sh_r;
        rx_sh_s      = rx_sh_r;
        gnt_s        = gnt_r;
        done_s       = '0;
        rx_data_s    = rx_data_r;
        busy_s       = busy_r;
        frame_done_s = 1'b0;
        sclk_s       = sclk_r;
        latch_s      = latch_r;
`ifndef SPI_SCHED_FIXED_PRIO_EN
        rr_ptr_s     = rr_ptr_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_s   = ST_SETUP;
                    gnt_s     = NUM_REQ'(1) << win_idx_s;
                    busy_s    = 1'b1;
                    latch_s   = 1'b0;
                    tx_sh_s   = win_word_s;
                    rx_sh_s   = '0;
                    div_cnt_s = '0;
                    bit_cnt_s = '0;
`ifndef SPI_SCHED_FIXED_PRIO_EN
                    rr_ptr_s  = win_idx_s;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            // First low half-period; ends with the first rising sclk edge.
            ST_SETUP: begin
                if (div_cnt_r == DIV_LAST) begin
                    div_cnt_s = '0;
                    sclk_s    = 1'b1;
                    rx_sh_s   = {rx_sh_r[DATA_W-2:0], miso};
                    state_s   = ST_SHIFT;
                end else begin
                    div_cnt_s = div_cnt_r + DIV_W'(1);
                end
            end
            ST_SHIFT: begin
                if (div_cnt_r == DIV_LAST) begin
                    div_cnt_s = '0;
                    if (sclk_r) begin
                        // Falling edge: advance mosi. After the last bit the
                        // register holds only shifted-in zeros, so mosi is 0.
                        sclk_s    = 1'b0;
                        tx_sh_s   = {tx_sh_r[DATA_W-2:0], 1'b0};
                        bit_cnt_s = bit_cnt_r + BIT_W'(1);
                        if (bit_cnt_r == BIT_LAST) begin
                            state_s = ST_HOLD;
                        end else begin
                            state_s = ST_SHIFT;
                        end
                    end else begin
                        sclk_s  = 1'b1;
                        rx_sh_s = {rx_sh_r[DATA_W-2:0], miso};
                    end
                end else begin
                    div_cnt_s = div_cnt_r + DIV_W'(1);
                end
            end
            // Chip select stays low one more half-period after the last fall.
            ST_HOLD: begin
                if (div_cnt_r == DIV_LAST) begin
                    div_cnt_s    = '0;
                    latch_s      = 1'b1;
                    rx_data_s    = rx_sh_r;
                    done_s       = gnt_r;
                    frame_done_s = 1'b1;
                    gnt_s        = '0;
                    gap_cnt_s    = '0;
                    state_s      = ST_GAP;
                end else begin
                    div_cnt_s = div_cnt_r + DIV_W'(1);
                end
            end
            // busy stays high for CS_GAP cycles, then one idle-settle cycle.
            ST_GAP: begin
                if (gap_cnt_r == GAP_END) begin
                    state_s = ST_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r + GAP_W'(1);
                    if (gap_cnt_r == GAP_LAST) begin
                        busy_s = 1'b0;
                    end else begin
                        busy_s = busy_r;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            div_cnt_r    <= '0;
            bit_cnt_r    <= '0;
            gap_cnt_r    <= '0;
            tx_sh_r      <= '0;
            rx_sh_r      <= '0;
            gnt_r        <= '0;
            done_r       <= '0;
            rx_data_r    <= '0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            sclk_r       <= 1'b0;
            latch_r      <= 1'b1;
`ifndef SPI_SCHED_FIXED_PRIO_EN
            rr_ptr_r     <= PTR_W'(NUM_REQ - 1);
`endif
        end else begin
            state_r      <= state_s;
            div_cnt_r    <= div_cnt_s;
            bit_cnt_r    <= bit_cnt_s;
            gap_cnt_r    <= gap_cnt_s;
            tx_sh_r      <= tx_sh_s;
            rx_sh_r      <= rx_sh_s;
            gnt_r        <= gnt_s;
            done_r       <= done_s;
            rx_data_r    <= rx_data_s;
            busy_r       <= busy_s;
            frame_done_r <= frame_done_s;
            sclk_r       <= sclk_s;
            latch_r      <= latch_s;
`ifndef SPI_SCHED_FIXED_PRIO_EN
            rr_ptr_r     <= rr_ptr_s;
`endif
        end
    end

    assign gnt        = gnt_r;
    assign done       = done_r;
    assign rx_data    = rx_data_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign sclk       = sclk_r;
    assign latch      = latch_r;
    assign mosi       = tx_sh_r[DATA_W-1];

endmodule

// File: tb/tb_spi_master_sched.sv
// -----------------------------------------------------------------------------
// tb_spi_master_sched
//   Self-checking bench for spi_master_sched with default parameters.
//   A table of frames plus hand-written corner sequences and randomized
//   frames. Expected grants come from a requester-order model; expected
//   serial timing comes from the edge schedule relative to latch fall.
// -----------------------------------------------------------------------------
module tb_spi_master_sched;

    localparam int NR       = 2;
    localparam int DW       = 8;
    localparam int CD       = 4;
    localparam int CG       = 2;
    localparam int LAT_RISE = CD * (2 * DW + 1);

    logic           clk_in;
    logic           reset;
    logic [NR-1:0]  req;
    logic [NR*DW-1:0] tx_data;
    logic [NR-1:0]  gnt;
    logic [NR-1:0]  done;
    logic [DW-1:0]  rx_data;
    logic           busy;
    logic           frame_done;
    logic           sclk;
    logic           latch;
    logic           mosi;
    logic           miso;

    int n_cmp;
    int n_fail;
    int last_win;

    typedef struct {
        logic [1:0] rq;
        logic [7:0] t0;
        logic [7:0] t1;
        logic [7:0] sl;
        logic [1:0] eg;
        logic [7:0] erx;
    } vec_t;

    vec_t tbl[5];

    spi_master_sched #(.NUM_REQ(NR), .DATA_W(DW), .CLK_DIV(CD), .CS_GAP(CG)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .req        (req),
        .tx_data    (tx_data),
        .gnt        (gnt),
        .done       (done),
        .rx_data    (rx_data),
        .busy       (busy),
        .frame_done (frame_done),
        .sclk       (sclk),
        .latch      (latch),
        .mosi       (mosi),
        .miso       (miso)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference arbitration: walk requesters in order starting after the last
    // winner (round-robin) or from index 0 (fixed priority).
    function automatic int pick(input logic [1:0] rq);
        int order[$];
`ifdef SPI_SCHED_FIXED_PRIO_EN
        for (int k = 0; k < NR; k++) order.push_back(k);
`else
        for (int k = 1; k <= NR; k++) order.push_back((last_win + k) % NR);
`endif
        foreach (order[j]) begin
            if (rq[order[j]]) return order[j];
        end
        return -1;
    endfunction

    // Runs one frame: applies the request, acts as SPI slave sending sl, and
    // checks grant, edge timing, mosi bits and end-of-frame outputs.
    task automatic run_frame(input string nm, input logic [1:0] rq, input logic [7:0] t0,
                             input logic [7:0] t1, input logic [7:0] sl, input logic [1:0] eg,
                             input logic [7:0] erx, input bit pulse);
        logic [7:0] w;
        int n, rises, lat, mi;
        logic ps;
        bit early;
        w       = (eg == 2'b10) ? t1 : t0;
        req     = rq;
        tx_data = {t1, t0};
        mi      = DW - 1;
        miso    = sl[DW-1];
        tick;
        n = 1;
        if (pulse) req = 2'b00;
        while (gnt == 2'b00 && n < 50) begin
            tick;
            n++;
        end
        // Mid-frame changes must be ignored.
        req     = 2'b00;
        tx_data = ~{t1, t0};
        check({nm, " gnt"}, 32'(gnt), 32'(eg));
        check({nm, " latch0"}, 32'(latch), 32'd0);
        check({nm, " busy0"}, 32'(busy), 32'd1);
        check({nm, " mosi0"}, 32'(mosi), 32'(w[DW-1]));
        rises = 0;
        lat   = -1;
        early = 1'b0;
        ps    = sclk;
        for (int c = 1; c <= 200; c++) begin
            tick;
            if (latch) begin
                lat = c;
                break;
            end
            if (done != 2'b00) early = 1'b1;
            if (sclk && !ps) begin
                check({nm, " rise_t"}, 32'(c), 32'(CD * (2 * rises + 1)));
                if (rises < DW) check({nm, " mosi"}, 32'(mosi), 32'(w[DW-1-rises]));
                rises++;
            end else if (!sclk && ps) begin
                mi--;
                miso = (mi >= 0) ? sl[mi] : 1'b0;
            end
            ps = sclk;
        end
        check({nm, " lat_rise"}, 32'(lat), 32'(LAT_RISE));
        check({nm, " rises"}, 32'(rises), 32'(DW));
        check({nm, " early_done"}, 32'(early), 32'd0);
        check({nm, " done"}, 32'(done), 32'(eg));
        check({nm, " frame_done"}, 32'(frame_done), 32'd1);
        check({nm, " rx_data"}, 32'(rx_data), 32'(erx));
        check({nm, " gnt_end"}, 32'(gnt), 32'd0);
        check({nm, " sclk_end"}, 32'(sclk), 32'd0);
        check({nm, " mosi_end"}, 32'(mosi), 32'd0);
        tick;
        check({nm, " busy_gap"}, 32'(busy), 32'd1);
        check({nm, " done_pulse"}, 32'(done), 32'd0);
        tick;
        check({nm, " busy_off"}, 32'(busy), 32'd0);
        last_win = (eg == 2'b10) ? 1 : 0;
        miso = 1'b0;
    endtask

    initial begin
        int gcyc[3];
        logic [1:0] gval[3];
        int ng, d1, cnt, bad;
        logic [1:0] pg;
        logic [1:0] rq;
        logic [7:0] a, b, s;
        int wi;

        n_cmp    = 0;
        n_fail   = 0;
        last_win = NR - 1;
        reset    = 1'b1;
        req      = '0;
        tx_data  = '0;
        miso     = 1'b0;

        tbl[0] = '{2'b01, 8'hA5, 8'h00, 8'hA5, 2'b01, 8'hA5};
`ifdef SPI_SCHED_FIXED_PRIO_EN
        tbl[1] = '{2'b11, 8'h3C, 8'hC3, 8'h96, 2'b01, 8'h96};
`else
        tbl[1] = '{2'b11, 8'h3C, 8'hC3, 8'h96, 2'b10, 8'h96};
`endif
        tbl[2] = '{2'b11, 8'h3C, 8'hC3, 8'h69, 2'b01, 8'h69};
        tbl[3] = '{2'b10, 8'h11, 8'hFF, 8'h00, 2'b10, 8'h00};
        tbl[4] = '{2'b01, 8'h00, 8'h77, 8'hFF, 2'b01, 8'hFF};

        tick; tick; tick;
        reset = 1'b0;
        check("rst gnt", 32'(gnt), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst frame_done", 32'(frame_done), 32'd0);
        check("rst rx_data", 32'(rx_data), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst sclk", 32'(sclk), 32'd0);
        check("rst latch", 32'(latch), 32'd1);
        check("rst mosi", 32'(mosi), 32'd0);

        // No request, no frame.
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick;
            if (busy || !latch) bad++;
        end
        check("idle no frame", 32'(bad), 32'd0);

        // Single-cycle request pulse still yields a complete frame.
        run_frame("pulse", 2'b10, 8'h00, 8'hFF, 8'h00, 2'b10, 8'h00, 1'b1);

        for (int i = 0; i < 5; i++) begin
            run_frame($sformatf("tbl%0d", i), tbl[i].rq, tbl[i].t0, tbl[i].t1,
                      tbl[i].sl, tbl[i].eg, tbl[i].erx, 1'b0);
        end

        // Reset in the middle of a frame aborts it without done.
        req = 2'b01;
        tx_data = {8'h00, 8'hA5};
        cnt = 0;
        tick;
        while (gnt == 2'b00 && cnt < 50) begin
            tick;
            cnt++;
        end
        req = 2'b00;
        for (int c = 0; c < 30; c++) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("midrst latch", 32'(latch), 32'd1);
        check("midrst sclk", 32'(sclk), 32'd0);
        check("midrst gnt", 32'(gnt), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst rx_data", 32'(rx_data), 32'd0);
        check("midrst mosi", 32'(mosi), 32'd0);
        bad = 0;
        for (int c = 0; c < 80; c++) begin
            tick;
            if (done != 2'b00 || frame_done || !latch) bad++;
        end
        check("midrst quiet", 32'(bad), 32'd0);
        last_win = NR - 1;

        // Both requesters held: grant order and gnt-to-gnt period.
        req = 2'b11;
        tx_data = {8'hC3, 8'h3C};
        ng = 0;
        d1 = 0;
        pg = 2'b00;
        for (int c = 0; c < 400 && ng < 3; c++) begin
            tick;
            if (done[1]) d1++;
            if (gnt != 2'b00 && pg == 2'b00) begin
                gcyc[ng] = c;
                gval[ng] = gnt;
                ng++;
            end
            pg = gnt;
        end
        req = 2'b00;
        check("held ngrants", 32'(ng), 32'd3);
`ifdef SPI_SCHED_FIXED_PRIO_EN
        check("held g1", 32'(gval[1]), 32'h1);
        check("held done1", 32'(d1), 32'd0);
`else
        check("held g1", 32'(gval[1]), 32'h2);
        check("held done1", 32'(d1), 32'd1);
`endif
        check("held g0", 32'(gval[0]), 32'h1);
        check("held g2", 32'(gval[2]), 32'h1);
        check("held period01", 32'(gcyc[1] - gcyc[0]), 32'd72);
        check("held period12", 32'(gcyc[2] - gcyc[1]), 32'd72);
        cnt = 0;
        while (busy && cnt < 200) begin
            tick;
            cnt++;
        end
        check("held drain", 32'(busy), 32'd0);
        last_win = 0;

        // Randomized frames against the reference arbitration and slave data.
        for (int i = 0; i < 8; i++) begin
            rq = 2'($urandom_range(1, 3));
            a  = 8'($urandom);
            b  = 8'($urandom);
            s  = 8'($urandom);
            wi = pick(rq);
            run_frame($sformatf("rnd%0d", i), rq, a, b, s, 2'(2'b01 << wi), s, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
